// File: rtl/divider_unit.sv
// 32-bit restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle, with bypass of
// divide-by-zero and signed overflow. Optional DIVIDER_EARLY_OUT_EN skips CALC when |a| < |b|.
module divider_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  alu_function,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        valid,
  output logic [31:0] result
);

  localparam logic [4:0] ALU_DIV  = 5'd16;
  localparam logic [4:0] ALU_DIVU = 5'd17;
  localparam logic [4:0] ALU_REM  = 5'd18;
  localparam logic [4:0] ALU_REMU = 5'd19;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t      state, next_state;
  logic [4:0]  op_q;
  logic [31:0] quot_q;     // dividend magnitude shifting out, quotient bits shifting in
  logic [31:0] div_q;
  logic [31:0] rem_q;
  logic [5:0]  count_q;
  logic        quot_neg_q, rem_neg_q;

  logic        is_div_op, is_signed_in, is_quot_in, a_neg_in, b_neg_in;
  logic [31:0] a_mag_in, b_mag_in;
  logic        div_zero, sign_ovf, early_out, bypass, accept;
  logic [31:0] bypass_result;

  logic [32:0] shifted, diff;
  logic        q_bit, last_iter, is_quot_op;
  logic [31:0] iter_quot, iter_rem, calc_result;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    is_div_op    = (alu_function inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU});
    is_signed_in = (alu_function == ALU_DIV) || (alu_function == ALU_REM);
    is_quot_in   = (alu_function == ALU_DIV) || (alu_function == ALU_DIVU);
    a_neg_in     = is_signed_in && operand_a[31];
    b_neg_in     = is_signed_in && operand_b[31];
    a_mag_in     = a_neg_in ? -operand_a : operand_a;
    b_mag_in     = b_neg_in ? -operand_b : operand_b;
    div_zero     = (operand_b == 32'd0);
    sign_ovf     = is_signed_in && (operand_a == 32'h8000_0000) && (operand_b == 32'hFFFF_FFFF);
`ifdef DIVIDER_EARLY_OUT_EN
    early_out    = !div_zero && (a_mag_in < b_mag_in);
`else
    early_out    = 1'b0;
`endif
    bypass       = div_zero || sign_ovf || early_out;
    accept       = (state == IDLE) && start && is_div_op;

    bypass_result = operand_a;
    if (div_zero)      bypass_result = is_quot_in ? 32'hFFFF_FFFF : operand_a;
    else if (sign_ovf) bypass_result = is_quot_in ? 32'h8000_0000 : 32'd0;
    else               bypass_result = is_quot_in ? 32'd0 : operand_a;
  end

  // One restoring step: subtract if the shifted partial remainder covers the divisor.
  always_comb begin
    shifted     = {rem_q, quot_q[31]};
    diff        = shifted - {1'b0, div_q};
    q_bit       = !diff[32];
    iter_rem    = q_bit ? diff[31:0] : shifted[31:0];
    iter_quot   = {quot_q[30:0], q_bit};
    last_iter   = (count_q == 6'd31);
    is_quot_op  = (op_q == ALU_DIV) || (op_q == ALU_DIVU);
    calc_result = is_quot_op ? (quot_neg_q ? -iter_quot : iter_quot)
                             : (rem_neg_q  ? -iter_rem  : iter_rem);
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = bypass ? DONE : CALC;
      CALC:    if (last_iter) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_q       <= 5'd0;
      quot_q     <= 32'd0;
      div_q      <= 32'd0;
      rem_q      <= 32'd0;
      count_q    <= 6'd0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      result     <= 32'd0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          op_q       <= alu_function;
          quot_q     <= a_mag_in;
          div_q      <= b_mag_in;
          rem_q      <= 32'd0;
          count_q    <= 6'd0;
          quot_neg_q <= a_neg_in ^ b_neg_in;
          rem_neg_q  <= a_neg_in;
          if (bypass) result <= bypass_result;
        end
        CALC: begin
          quot_q  <= iter_quot;
          rem_q   <= iter_rem;
          count_q <= count_q + 6'd1;
          if (last_iter) result <= calc_result;
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign valid = (state == DONE);

endmodule

// File: tb/tb_divider_unit.sv
// Scoreboard bench for divider_unit: directed vectors push expected results and cycles,
// a negedge monitor pops and compares on every valid pulse.
module tb_divider_unit;

  localparam logic [4:0] ALU_DIV  = 5'd16;
  localparam logic [4:0] ALU_DIVU = 5'd17;
  localparam logic [4:0] ALU_REM  = 5'd18;
  localparam logic [4:0] ALU_REMU = 5'd19;
`ifdef DIVIDER_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 33;
`endif

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       name;
  } exp_t;

  logic        clk, reset, start;
  logic [4:0]  alu_function;
  logic [31:0] operand_a, operand_b;
  logic        busy, valid;
  logic [31:0] result;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   busy_cnt;
  int   k;
  exp_t sb[$];
  exp_t got;
  logic prev_valid = 1'b0;

  divider_unit dut (
    .clock       (clk),
    .reset       (reset),
    .start       (start),
    .alu_function(alu_function),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .busy        (busy),
    .valid       (valid),
    .result      (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      check("valid_gap", 32'(prev_valid), 32'd0);
      check("valid_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        got = sb.pop_front();
        check({got.name, "_result"}, result, got.res);
        check({got.name, "_cycle"}, 32'(cyc), 32'(got.cyc));
      end
    end
    prev_valid <= valid;
  end

  task automatic wait_done();
    for (int i = 0; i < 80; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    check("drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input int lat, input string name);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; alu_function = op; operand_a = a; operand_b = b;
    e.res = res; e.cyc = cyc + lat; e.name = name;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; alu_function = 5'd0; operand_a = 32'd0; operand_b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_result", result, 32'd0);
    reset = 1'b0;

    issue(ALU_DIVU, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
    issue(ALU_REMU, 32'd100, 32'd7, 32'd2, 33, "remu_100_7");
    issue(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2");
    issue(ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7_2");
    issue(ALU_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_7_m2");
    issue(ALU_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, "rem_7_m2");
    issue(ALU_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 33, "div_m100_m7");
    issue(ALU_REM, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 33, "rem_m100_m7");
    issue(ALU_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, "divu_max_1");
    issue(ALU_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33, "divu_max_max");
    issue(ALU_REMU, 32'hFFFF_FFFF, 32'd16, 32'd15, 33, "remu_max_16");

    issue(ALU_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div_5_0");
    issue(ALU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_5_0");
    issue(ALU_REM, 32'd5, 32'd0, 32'd5, 1, "rem_5_0");
    issue(ALU_REMU, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 1, "remu_x_0");
    issue(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    issue(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");

    issue(ALU_DIVU, 32'd3, 32'd10, 32'd0, EO_LAT, "divu_3_10");
    issue(ALU_REMU, 32'd3, 32'd10, 32'd3, EO_LAT, "remu_3_10");
    issue(ALU_DIVU, 32'd0, 32'd5, 32'd0, EO_LAT, "divu_0_5");

    // Start with a non-divide opcode must be ignored.
    @(posedge clk); #1;
    start = 1'b1; alu_function = 5'd0; operand_a = 32'd10; operand_b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    check("illegal_op_busy", 32'(busy), 32'd0);
    repeat (40) @(posedge clk);

    // Second start at cycle 10 while busy is dropped; busy spans cycles 1..33.
    @(posedge clk); #1;
    k = cyc;
    start = 1'b1; alu_function = ALU_DIVU; operand_a = 32'd100; operand_b = 32'd7;
    sb.push_back('{res: 32'd14, cyc: k + 33, name: "busy_window"});
    busy_cnt = 0;
    for (int i = 1; i <= 33; i++) begin
      @(posedge clk); #1;
      if (i == 1) start = 1'b0;
      if (i == 10) begin
        start = 1'b1; alu_function = ALU_REMU; operand_a = 32'd50; operand_b = 32'd5;
      end
      if (i == 11) start = 1'b0;
      if (busy) busy_cnt++;
    end
    check("busy_window_cycles", 32'(busy_cnt), 32'd33);
    @(posedge clk); #1;
    check("busy_window_release", 32'(busy), 32'd0);
    wait_done();
    repeat (40) @(posedge clk);

    // Reset at cycle 15 aborts; a start in the reset cycle is ignored.
    @(posedge clk); #1;
    k = cyc;
    start = 1'b1; alu_function = ALU_DIVU; operand_a = 32'h0000_FFFF; operand_b = 32'd3;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk); #1;
      if (i == 1) start = 1'b0;
      if (i == 15) begin
        reset = 1'b1; start = 1'b1; operand_a = 32'd9; operand_b = 32'd3;
      end
    end
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_result", result, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("abort_idle", 32'(busy), 32'd0);
    issue(ALU_DIVU, 32'd9, 32'd3, 32'd3, 33, "divu_9_3_after_reset");

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
